// File: rtl/prim_flop_pipe_stage.sv
// prim_flop_pipe_stage: one elastic register slice; in_valid/in_data/in_ready upstream, out_valid/out_data/out_ready downstream, flush clears valid
module prim_flop_pipe_stage #(
    parameter int               Width      = 8,
    parameter logic [Width-1:0] ResetValue = '0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             in_valid,
    input  logic [Width-1:0] in_data,
    input  logic             out_ready,
    input  logic             flush,
    output logic             out_valid,
    output logic [Width-1:0] out_data,
    output logic             in_ready
);
    assign in_ready = !out_valid || out_ready;
    always_ff @(posedge clk_i or negedge rst_ni)
        if (!rst_ni) begin
            out_valid <= 1'b0;
            out_data  <= ResetValue;
        end else begin
            out_valid <= flush ? 1'b0 : in_ready ? in_valid : out_valid;
            if (!flush && in_ready && in_valid) out_data <= in_data;
        end
endmodule

// File: rtl/prim_flop_pipe.sv
// prim_flop_pipe: Depth-stage elastic valid/ready pipeline; valid_i/data_i/ready_o in, valid_o/data_o/ready_i out, flush_i drops all, count_o occupancy
module prim_flop_pipe #(
    parameter int               Width      = 8,
    parameter int               Depth      = 2,
    parameter logic [Width-1:0] ResetValue = '0,
    localparam int              CntW       = $clog2(Depth + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             valid_i,
    input  logic [Width-1:0] data_i,
    output logic             ready_o,
    input  logic             flush_i,
    output logic             valid_o,
    output logic [Width-1:0] data_o,
    input  logic             ready_i,
    output logic [CntW-1:0]  count_o
);
    if (Depth < 1) begin : g_bad_depth
        $error("prim_flop_pipe: Depth must be >= 1");
    end
    logic [Depth:0]   v;
    logic [Depth:0]   rdy;
    logic [Width-1:0] d [Depth+1];
    assign v[0]       = valid_i;
    assign d[0]       = data_i;
    assign rdy[Depth] = ready_i;
    for (genvar g = 0; g < Depth; g++) begin : g_stage
        prim_flop_pipe_stage #(
            .Width     (Width),
            .ResetValue(ResetValue)
        ) u_stage (
            .clk_i    (clk_i),
            .rst_ni   (rst_ni),
            .in_valid (v[g]),
            .in_data  (d[g]),
            .out_ready(rdy[g+1]),
            .flush    (flush_i),
            .out_valid(v[g+1]),
            .out_data (d[g+1]),
            .in_ready (rdy[g])
        );
    end
    assign ready_o = rdy[0] && !flush_i;
    assign valid_o = v[Depth];
    assign data_o  = d[Depth];
    always_comb begin
        count_o = '0;
        for (int i = 1; i <= Depth; i++) count_o = count_o + CntW'(v[i]);
    end
endmodule
